uart_cfg: RTL and testbench

UART_CFG -- requirements
Module: uart_cfg

---
 rtl/uart_cfg.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - configurable UART transmitter and receiver with one-entry TX holding register
//
// Parameters: CLOCK_FREQUENCY (Hz), BAUD_RATE (bit/s), DATA_BITS (5..9),
//             PARITY (0 none, 1 odd, 2 even), STOP_BITS (1 or 2)
// Ports:
//   clockIN           in   single clock, rising edge
//   resetIN           in   synchronous active-high reset
//   txDataIN          in   word to transmit, LSB first
//   txLoadIN          in   load strobe, accepted while txReadyOUT=1
//   txReadyOUT        out  holding register empty
//   txIdleOUT         out  TX FSM idle and holding register empty
//   txOUT             out  serial line, idles high
//   rxIN              in   asynchronous serial line
//   rxIdleOUT         out  RX FSM idle
//   rxReadyOUT        out  one-cycle pulse per received frame
//   rxDataOUT         out  last received word, held
//   rxParityErrorOUT  out  parity mismatch of last frame, held
//   rxFrameErrorOUT   out  a stop bit of last frame sampled low, held
module uart_cfg #(
    parameter int CLOCK_FREQUENCY = 25_000_000,
    parameter int BAUD_RATE       = 921600,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clockIN,
    input  logic                 resetIN,
    input  logic [DATA_BITS-1:0] txDataIN,
    input  logic                 txLoadIN,
    output logic                 txReadyOUT,
    output logic                 txIdleOUT,
    output logic                 txOUT,
    input  logic                 rxIN,
    output logic                 rxIdleOUT,
    output logic                 rxReadyOUT,
    output logic [DATA_BITS-1:0] rxDataOUT,
    output logic                 rxParityErrorOUT,
    output logic                 rxFrameErrorOUT
);

    localparam int CLKS_PER_BIT = (BAUD_RATE > 0) ? (CLOCK_FREQUENCY / BAUD_RATE) : 0;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT < 8) ? 4 : $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : gParamCheck
            $error("uart_cfg: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uartState;

    // Even mode: parity bit equals XOR of data. Odd mode: its complement.
    function automatic logic parityBit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    // ---------------------------------------------------------------- TX
    uartState               txState;
    logic [CNT_W-1:0]       txCnt;
    logic [3:0]             txBitIdx;
    logic                   txStopIdx;
    logic [DATA_BITS-1:0]   txShift;
    logic                   txParBit;
    logic [DATA_BITS-1:0]   holdData;
    logic                   holdFull;
    logic                   txBitEnd;

    assign txBitEnd   = (txCnt == BIT_LAST);
    assign txReadyOUT = ~holdFull;
    assign txIdleOUT  = (txState == IDLE) && !holdFull;

    always_ff @(posedge clockIN) begin
        if (resetIN) begin
            txState   <= IDLE;
            txCnt     <= '0;
            txBitIdx  <= '0;
            txStopIdx <= 1'b0;
            txShift   <= '0;
            txParBit  <= 1'b0;
            holdData  <= '0;
            holdFull  <= 1'b0;
            txOUT     <= 1'b1;
        end else begin
            // Load and transfer are mutually exclusive: one needs the holding register empty, the other full.
            if (txLoadIN && !holdFull) begin
                holdData <= txDataIN;
                holdFull <= 1'b1;
            end
            case (txState)
                IDLE: begin
                    txOUT <= 1'b1;
                    txCnt <= '0;
                    if (holdFull) begin
                        txShift  <= holdData;
                        txParBit <= parityBit(holdData);
                        holdFull <= 1'b0;
                        txOUT    <= 1'b0;
                        txState  <= START;
                    end
                end
                START: begin
                    if (txBitEnd) begin
                        txCnt    <= '0;
                        txBitIdx <= '0;
                        txOUT    <= txShift[0];
                        txState  <= DATA;
                    end else begin
                        txCnt <= txCnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (txBitEnd) begin
                        txCnt <= '0;
                        if (txBitIdx == DATA_LAST) begin
                            txStopIdx <= 1'b0;
                            if (PARITY != 0) begin
                                txOUT   <= txParBit;
                                txState <= PAR;
                            end else begin
                                txOUT   <= 1'b1;
                                txState <= STOP;
                            end
                        end else begin
                            txShift  <= txShift >> 1;
                            txOUT    <= txShift[1];
                            txBitIdx <= txBitIdx + 4'd1;
                        end
                    end else begin
                        txCnt <= txCnt + CNT_W'(1);
                    end
                end
                PAR: begin
                    if (txBitEnd) begin
                        txCnt   <= '0;
                        txOUT   <= 1'b1;
                        txState <= STOP;
                    end else begin
                        txCnt <= txCnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (txBitEnd) begin
                        txCnt <= '0;
                        if (txStopIdx == STOP_LAST) begin
                            // A pending word starts right here so consecutive frames have no idle gap.
                            if (holdFull) begin
                                txShift  <= holdData;
                                txParBit <= parityBit(holdData);
                                holdFull <= 1'b0;
                                txOUT    <= 1'b0;
                                txState  <= START;
                            end else begin
                                txOUT   <= 1'b1;
                                txState <= IDLE;
                            end
                        end else begin
                            txStopIdx <= 1'b1;
                        end
                    end else begin
                        txCnt <= txCnt + CNT_W'(1);
                    end
                end
                default: begin
                    txOUT   <= 1'b1;
                    txState <= IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- RX
    uartState               rxState;
    logic                   rxMeta;
    logic                   rxSync;
    logic                   rxArmed;
    logic [CNT_W-1:0]       rxCnt;
    logic [3:0]             rxBitIdx;
    logic                   rxStopIdx;
    logic [DATA_BITS-1:0]   rxShift;
    logic                   rxParSample;
    logic                   rxStopErr;
    logic                   rxBitEnd;

    assign rxBitEnd  = (rxCnt == BIT_LAST);
    assign rxIdleOUT = (rxState == IDLE);

    always_ff @(posedge clockIN) begin
        if (resetIN) begin
            rxMeta           <= 1'b1;
            rxSync           <= 1'b1;
            rxArmed          <= 1'b0;
            rxState          <= IDLE;
            rxCnt            <= '0;
            rxBitIdx         <= '0;
            rxStopIdx        <= 1'b0;
            rxShift          <= '0;
            rxParSample      <= 1'b0;
            rxStopErr        <= 1'b0;
            rxReadyOUT       <= 1'b0;
            rxDataOUT        <= '0;
            rxParityErrorOUT <= 1'b0;
            rxFrameErrorOUT  <= 1'b0;
        end else begin
            rxMeta     <= rxIN;
            rxSync     <= rxMeta;
            rxReadyOUT <= 1'b0;
            case (rxState)
                IDLE: begin
                    rxCnt <= '0;
                    // A start bit is only accepted once the line has been seen high, so a
                    // line stuck low after a framing error does not retrigger reception.
                    if (rxSync) begin
                        rxArmed <= 1'b1;
                    end else if (rxArmed) begin
                        rxArmed <= 1'b0;
                        rxState <= START;
                    end
                end
                START: begin
                    if (rxCnt == HALF_LAST) begin
                        rxCnt <= '0;
                        if (rxSync) begin
                            rxState <= IDLE;
                        end else begin
                            rxBitIdx <= '0;
                            rxState  <= DATA;
                        end
                    end else begin
                        rxCnt <= rxCnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (rxBitEnd) begin
                        rxCnt   <= '0;
                        rxShift <= {rxSync, rxShift[DATA_BITS-1:1]};
                        if (rxBitIdx == DATA_LAST) begin
                            rxStopIdx <= 1'b0;
                            rxStopErr <= 1'b0;
                            rxState   <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            rxBitIdx <= rxBitIdx + 4'd1;
                        end
                    end else begin
                        rxCnt <= rxCnt + CNT_W'(1);
                    end
                end
                PAR: begin
                    if (rxBitEnd) begin
                        rxCnt       <= '0;
                        rxParSample <= rxSync;
                        rxState     <= STOP;
                    end else begin
                        rxCnt <= rxCnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (rxBitEnd) begin
                        rxCnt <= '0;
                        if (rxStopIdx == STOP_LAST) begin
                            rxDataOUT        <= rxShift;
                            rxParityErrorOUT <= (PARITY != 0) && (rxParSample != parityBit(rxShift));
                            rxFrameErrorOUT  <= rxStopErr | ~rxSync;
                            rxReadyOUT       <= 1'b1;
                            rxState          <= IDLE;
                        end else begin
                            rxStopErr <= ~rxSync;
                            rxStopIdx <= 1'b1;
                        end
                    end else begin
                        rxCnt <= rxCnt + CNT_W'(1);
                    end
                end
                default: rxState <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cfg.sv
// tb/tb_uart_cfg.sv - directed self-checking bench for uart_cfg in 8N1, 8E1 and 7O2 configurations
module tb_uart_cfg;

    localparam int CPB = 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: 8N1, line selectable between loopback and bench drive
    logic [7:0] aTxData, aRxData;
    logic aTxLoad, aTxReady, aTxIdle, aTx, aRx, aRxIdle, aRxReady, aRxPerr, aRxFerr;
    logic aLoop, aRxDrv;
    assign aRx = aLoop ? aTx : aRxDrv;

    // Instance B: 8E1, permanent loopback
    logic [7:0] bTxData, bRxData;
    logic bTxLoad, bTxReady, bTxIdle, bTx, bRxIdle, bRxReady, bRxPerr, bRxFerr;

    // Instance C: 7O2, receive side driven by the bench
    logic [6:0] cTxData, cRxData;
    logic cTxLoad, cTxReady, cTxIdle, cTx, cRxDrv, cRxIdle, cRxReady, cRxPerr, cRxFerr;

    uart_cfg uA (
        .clockIN(clk), .resetIN(rst), .txDataIN(aTxData), .txLoadIN(aTxLoad),
        .txReadyOUT(aTxReady), .txIdleOUT(aTxIdle), .txOUT(aTx), .rxIN(aRx),
        .rxIdleOUT(aRxIdle), .rxReadyOUT(aRxReady), .rxDataOUT(aRxData),
        .rxParityErrorOUT(aRxPerr), .rxFrameErrorOUT(aRxFerr)
    );

    uart_cfg #(.PARITY(2)) uB (
        .clockIN(clk), .resetIN(rst), .txDataIN(bTxData), .txLoadIN(bTxLoad),
        .txReadyOUT(bTxReady), .txIdleOUT(bTxIdle), .txOUT(bTx), .rxIN(bTx),
        .rxIdleOUT(bRxIdle), .rxReadyOUT(bRxReady), .rxDataOUT(bRxData),
        .rxParityErrorOUT(bRxPerr), .rxFrameErrorOUT(bRxFerr)
    );

    uart_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) uC (
        .clockIN(clk), .resetIN(rst), .txDataIN(cTxData), .txLoadIN(cTxLoad),
        .txReadyOUT(cTxReady), .txIdleOUT(cTxIdle), .txOUT(cTx), .rxIN(cRxDrv),
        .rxIdleOUT(cRxIdle), .rxReadyOUT(cRxReady), .rxDataOUT(cRxData),
        .rxParityErrorOUT(cRxPerr), .rxFrameErrorOUT(cRxFerr)
    );

    int vectors = 0;
    int miscompares = 0;
    int aPulses = 0, bPulses = 0, cPulses = 0;
    int base;
    logic [9:0]  expBits;
    logic [29:0] qBits;

    // Counts high cycles of each rxReadyOUT, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (aRxReady === 1'b1) aPulses++;
        if (bRxReady === 1'b1) bPulses++;
        if (cRxReady === 1'b1) cPulses++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one 7O2 frame: start, 7 data bits LSB first, parity, stop1=1, stop2, then idle.
    task automatic driveFrameC(input logic [6:0] d, input logic par, input logic stop2);
        logic [10:0] bits;
        bits = {stop2, 1'b1, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            cRxDrv = bits[i];
            tick(CPB);
        end
        cRxDrv = 1'b1;
        tick(2 * CPB);
    endtask

    initial begin
        rst = 1'b1;
        aTxData = '0; aTxLoad = 1'b0; aLoop = 1'b1; aRxDrv = 1'b1;
        bTxData = '0; bTxLoad = 1'b0;
        cTxData = '0; cTxLoad = 1'b0; cRxDrv = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        checkValue("rst_txOUT", aTx, 1);
        checkValue("rst_txReady", aTxReady, 1);
        checkValue("rst_txIdle", aTxIdle, 1);
        checkValue("rst_rxIdle", aRxIdle, 1);
        checkValue("rst_rxReady", aRxReady, 0);
        checkValue("rst_rxData", aRxData, 0);
        checkValue("rst_perr", aRxPerr, 0);
        checkValue("rst_ferr", aRxFerr, 0);
        checkValue("rst_c_txOUT", cTx, 1);
        checkValue("rst_c_txReady", cTxReady, 1);
        checkValue("rst_c_txIdle", cTxIdle, 1);
        checkValue("rst_c_rxIdle", cRxIdle, 1);

        // 8N1 frame 0xA5: start at N+2, each bit 27 cycles, idle again at N+272
        base = aPulses;
        aTxData = 8'hA5; aTxLoad = 1'b1;
        tick(1);
        aTxLoad = 1'b0;
        checkValue("a5_ready_n1", aTxReady, 0);
        checkValue("a5_line_n1", aTx, 1);
        tick(1);
        expBits = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                if (c == 0 || c == CPB - 1)
                    checkValue($sformatf("a5_bit%0d_c%0d", i, c), aTx, expBits[i]);
                if (i == 9 && c == CPB - 1)
                    checkValue("a5_idle_last", aTxIdle, 0);
                tick(1);
            end
        end
        checkValue("a5_idle_end", aTxIdle, 1);
        tick(20);
        checkValue("a5_rx_pulse", aPulses - base, 1);
        checkValue("a5_rx_data", aRxData, 8'hA5);
        checkValue("a5_rx_perr", aRxPerr, 0);
        checkValue("a5_rx_ferr", aRxFerr, 0);

        // Two queued frames 0x55 and 0x0F, third load while full is dropped
        base = aPulses;
        aTxData = 8'h55; aTxLoad = 1'b1;
        tick(1);
        aTxLoad = 1'b0;
        checkValue("q_ready_n1", aTxReady, 0);
        tick(1);
        checkValue("q_ready_n2", aTxReady, 1);
        aTxData = 8'h0F; aTxLoad = 1'b1;
        tick(1);
        checkValue("q_ready_n3", aTxReady, 0);
        aTxData = 8'hFF; aTxLoad = 1'b1;
        tick(1);
        aTxLoad = 1'b0;
        qBits = {10'h3FF, 1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
        for (int r = 2; r < 30 * CPB; r++) begin
            if (r % CPB == CPB / 2)
                checkValue($sformatf("q_bit%0d", r / CPB), aTx, qBits[r / CPB]);
            if (r == 10 * CPB - 1) begin
                checkValue("q_ready_last_stop", aTxReady, 0);
                checkValue("q_line_last_stop", aTx, 1);
            end
            if (r == 10 * CPB) begin
                checkValue("q_ready_after", aTxReady, 1);
                checkValue("q_contig_start", aTx, 0);
            end
            tick(1);
        end
        checkValue("q_rx_pulses", aPulses - base, 2);
        checkValue("q_rx_data", aRxData, 8'h0F);

        // False start: 5-cycle low glitch
        aLoop = 1'b0; aRxDrv = 1'b1;
        tick(5);
        base = aPulses;
        aRxDrv = 1'b0;
        tick(4);
        checkValue("fs_start_seen", aRxIdle, 0);
        tick(1);
        aRxDrv = 1'b1;
        tick(11);
        checkValue("fs_idle", aRxIdle, 1);
        tick(60);
        checkValue("fs_no_pulse", aPulses - base, 0);
        checkValue("fs_rxdata_held", aRxData, 8'h0F);

        // 8E1 loopback of 0x37: parity bit 1 on the line
        base = bPulses;
        bTxData = 8'h37; bTxLoad = 1'b1;
        tick(1);
        bTxLoad = 1'b0;
        tick(1);
        tick(8 * CPB + 13);
        checkValue("e_data7", bTx, 0);
        tick(CPB);
        checkValue("e_parity", bTx, 1);
        tick(CPB);
        checkValue("e_stop", bTx, 1);
        tick(CPB + 10);
        checkValue("e_rx_pulse", bPulses - base, 1);
        checkValue("e_rx_data", bRxData, 8'h37);
        checkValue("e_rx_perr", bRxPerr, 0);
        checkValue("e_rx_ferr", bRxFerr, 0);

        // 7O2 receive: bad parity, bad second stop, then clean frame
        base = cPulses;
        driveFrameC(7'h41, 1'b0, 1'b1);
        checkValue("o_perr_pulse", cPulses - base, 1);
        checkValue("o_perr_data", cRxData, 7'h41);
        checkValue("o_perr_flag", cRxPerr, 1);
        checkValue("o_perr_ferr", cRxFerr, 0);
        base = cPulses;
        driveFrameC(7'h41, 1'b1, 1'b0);
        checkValue("o_ferr_pulse", cPulses - base, 1);
        checkValue("o_ferr_data", cRxData, 7'h41);
        checkValue("o_ferr_perr", cRxPerr, 0);
        checkValue("o_ferr_flag", cRxFerr, 1);
        base = cPulses;
        driveFrameC(7'h2A, 1'b0, 1'b1);
        checkValue("o_ok_pulse", cPulses - base, 1);
        checkValue("o_ok_data", cRxData, 7'h2A);
        checkValue("o_ok_perr", cRxPerr, 0);
        checkValue("o_ok_ferr", cRxFerr, 0);

        // Reset in the middle of a looped-back frame
        aLoop = 1'b1;
        tick(5);
        base = aPulses;
        aTxData = 8'hC3; aTxLoad = 1'b1;
        tick(1);
        aTxLoad = 1'b0;
        tick(1 + 3 * CPB + 10);
        checkValue("rm_tx_busy", aTxIdle, 0);
        checkValue("rm_rx_busy", aRxIdle, 0);
        rst = 1'b1; aTxData = 8'h99; aTxLoad = 1'b1;
        tick(1);
        rst = 1'b0; aTxLoad = 1'b0;
        checkValue("rm_txOUT", aTx, 1);
        checkValue("rm_txReady", aTxReady, 1);
        checkValue("rm_txIdle", aTxIdle, 1);
        checkValue("rm_rxIdle", aRxIdle, 1);
        checkValue("rm_rxReady", aRxReady, 0);
        checkValue("rm_rxData", aRxData, 0);
        checkValue("rm_perr", aRxPerr, 0);
        checkValue("rm_ferr", aRxFerr, 0);
        tick(1);
        checkValue("rm_load_ignored", aTxIdle, 1);
        tick(60);
        checkValue("rm_no_pulse", aPulses - base, 0);
        checkValue("rm_line_idle", aTx, 1);
        base = aPulses;
        aTxData = 8'h3C; aTxLoad = 1'b1;
        tick(1);
        aTxLoad = 1'b0;
        tick(300);
        checkValue("rm_after_pulse", aPulses - base, 1);
        checkValue("rm_after_data", aRxData, 8'h3C);
        checkValue("rm_after_perr", aRxPerr, 0);
        checkValue("rm_after_ferr", aRxFerr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
